// File: rtl/dma_pkg.sv
// Shared constants for the DMA address generator: opcodes, control-register fields, default width.
package dma_pkg;

  localparam int W_DEFAULT = 8;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_WRCR   = 4'h1;
  localparam logic [3:0] OP_RDCR   = 4'h2;
  localparam logic [3:0] OP_WRWC   = 4'h3;
  localparam logic [3:0] OP_RDWC   = 4'h4;
  localparam logic [3:0] OP_WRAR   = 4'h5;
  localparam logic [3:0] OP_RDAC   = 4'h6;
  localparam logic [3:0] OP_REINIT = 4'h7;
  localparam logic [3:0] OP_LDAC   = 4'h8;
  localparam logic [3:0] OP_LDWC   = 4'h9;

  localparam logic [1:0] MODE_WC_DOWN = 2'b00;
  localparam logic [1:0] MODE_WC_UP   = 2'b01;
  localparam logic [1:0] MODE_AC_CMP  = 2'b10;
  localparam logic [1:0] MODE_FREE    = 2'b11;

  localparam int CR_DIR_BIT = 2;

  // Instructions that modify state and therefore swallow a coincident transfer strobe.
  function automatic logic is_write_op(input logic [3:0] op);
    case (op)
      OP_WRCR, OP_WRWC, OP_WRAR, OP_REINIT, OP_LDAC, OP_LDWC: is_write_op = 1'b1;
      default:                                              is_write_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dma_addr_gen_if.sv
// Instruction/transfer bus of the DMA address generator; master drives instructions, slave answers.
interface dma_addr_gen_if
  import dma_pkg::*;
#(
  parameter int W = W_DEFAULT
);
  logic [3:0]   instr;
  logic [W-1:0] din;
  logic         cnt_en;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic [W-1:0] addr;
  logic         done;

  modport master (
    output instr, din, cnt_en,
    input  dout, dout_valid, addr, done
  );

  modport slave (
    input  instr, din, cnt_en,
    output dout, dout_valid, addr, done
  );
endinterface

// File: rtl/dma_counter.sv
// W-bit counter with parallel load and up/down step; load wins over step.
module dma_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_step,
  input  logic         i_down,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= {W{1'b0}};
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_step) begin
      r_q <= i_down ? (r_q - {{(W-1){1'b0}}, 1'b1}) : (r_q + {{(W-1){1'b0}}, 1'b1});
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/dma_addr_gen.sv
// DMA address generator: instruction decode, control/reload registers, read-back and terminal-count compare.
module dma_addr_gen
  import dma_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  dma_addr_gen_if.slave bus
);
  logic [2:0]   r_cr;
  logic [W-1:0] r_wcr;
  logic [W-1:0] r_ar;
  logic [W-1:0] r_dout;
  logic         r_dout_valid;

  logic [W-1:0] w_ac;
  logic [W-1:0] w_wc;
  logic         w_ac_load;
  logic         w_wc_load;
  logic [W-1:0] w_ac_load_val;
  logic [W-1:0] w_wc_load_val;
  logic         w_done;
  logic         w_xfer;
  logic         w_wc_step;
  logic         w_wc_down;

  // Counter load decode
  always_comb begin
    w_ac_load     = 1'b0;
    w_wc_load     = 1'b0;
    w_ac_load_val = bus.din;
    w_wc_load_val = bus.din;
    case (bus.instr)
      OP_WRWC, OP_LDWC: w_wc_load = 1'b1;
      OP_WRAR, OP_LDAC: w_ac_load = 1'b1;
      OP_REINIT: begin
        w_ac_load     = 1'b1;
        w_wc_load     = 1'b1;
        w_ac_load_val = r_ar;
        w_wc_load_val = r_wcr;
      end
      default: begin
        w_ac_load = 1'b0;
        w_wc_load = 1'b0;
      end
    endcase
  end

  // Terminal-count compare, purely from registered state
  always_comb begin
    w_done = 1'b0;
    case (r_cr[1:0])
      MODE_WC_DOWN: w_done = (w_wc == {W{1'b0}});
      MODE_WC_UP:   w_done = (w_wc == r_wcr);
      MODE_AC_CMP:  w_done = (w_ac == r_wcr);
      MODE_FREE:    w_done = 1'b0;
      default:      w_done = 1'b0;
    endcase
  end

  assign w_xfer    = bus.cnt_en & ~w_done & ~is_write_op(bus.instr);
  assign w_wc_step = w_xfer & (r_cr[1:0] != MODE_FREE);
  assign w_wc_down = (r_cr[1:0] == MODE_WC_DOWN);

  // Control and reload registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cr  <= 3'b000;
      r_wcr <= {W{1'b0}};
      r_ar  <= {W{1'b0}};
    end else begin
      case (bus.instr)
        OP_WRCR: r_cr  <= bus.din[2:0];
        OP_WRWC: r_wcr <= bus.din;
        OP_WRAR: r_ar  <= bus.din;
        default: r_cr  <= r_cr;
      endcase
    end
  end

  // Read-back: values are taken before this edge's counter update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout       <= {W{1'b0}};
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      case (bus.instr)
        OP_RDCR: begin
          r_dout       <= {{(W-3){1'b0}}, r_cr};
          r_dout_valid <= 1'b1;
        end
        OP_RDWC: begin
          r_dout       <= w_wc;
          r_dout_valid <= 1'b1;
        end
        OP_RDAC: begin
          r_dout       <= w_ac;
          r_dout_valid <= 1'b1;
        end
        default: r_dout <= r_dout;
      endcase
    end
  end

  dma_counter #(.W(W)) u_ac (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_ac_load),
    .i_load_val (w_ac_load_val),
    .i_step     (w_xfer),
    .i_down     (r_cr[CR_DIR_BIT]),
    .o_q        (w_ac)
  );

  dma_counter #(.W(W)) u_wc (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_wc_load),
    .i_load_val (w_wc_load_val),
    .i_step     (w_wc_step),
    .i_down     (w_wc_down),
    .o_q        (w_wc)
  );

  assign bus.addr       = w_ac;
  assign bus.done       = w_done;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
endmodule

// File: doc/dma_addr_gen.md
DMA_ADDR_GEN -- requirements
Module: dma_addr_gen

Interface
REQ-001 Parameter: W, default 8, width of the address, word-count and data paths.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 instr  input  4  instruction code, driven directly by the 4-bit instruction pipeline register; sampled every clk edge.
REQ-005 din  input  W  data operand for write/load instructions.
REQ-006 cnt_en  input  1  transfer strobe; advances the counters by one transfer.
REQ-007 dout  output  W  read-back data.
REQ-008 dout_valid  output  1  one-cycle pulse qualifying dout.
REQ-009 addr  output  W  current address counter value.
REQ-010 done  output  1  transfer-complete flag.

Function
REQ-011 Opcodes: 0x0 NOP; 0x1 WRCR cr<=din[2:0]; 0x2 RDCR; 0x3 WRWC wcr<=din and wc<=din; 0x4 RDWC; 0x5 WRAR ar<=din and ac<=din; 0x6 RDAC; 0x7 REINIT ac<=ar, wc<=wcr; 0x8 LDAC ac<=din only; 0x9 LDWC wc<=din only; 0xA-0xF NOP.
REQ-012 Reads: RDCR, RDWC and RDAC drive dout (RDCR zero-extended) one cycle after the instruction edge, with dout_valid=1 for exactly that cycle; dout holds its last value otherwise.
REQ-013 Read values are sampled pre-update: a read coinciding with cnt_en returns the value before the step.
REQ-014 cr[2] sets direction: 0 gives ac+1 per transfer, 1 gives ac-1; modulo 2^W wrap, no flag.
REQ-015 cr[1:0]=00: wc decrements per transfer; done=(wc==0).
REQ-016 cr[1:0]=01: wc increments per transfer; done=(wc==wcr).
REQ-017 cr[1:0]=10: wc increments per transfer; done=(ac==wcr).
REQ-018 cr[1:0]=11: wc holds; done=0 always; ac still steps.
REQ-019 done is combinational from registered cr/wc/ac/wcr; zero added latency.
REQ-020 A transfer executes when cnt_en=1, done=0 and instr is not a write/load/REINIT (0x1,0x3,0x5,0x7,0x8,0x9).
REQ-021 A transfer steps ac and wc (per mode) in the same edge.
REQ-022 With cnt_en=1 and done=1, the counters hold (halt at terminal count).
REQ-023 Write/load/REINIT take priority over cnt_en: that edge performs only the write; the strobe is dropped, not queued.
REQ-024 A read or NOP coinciding with cnt_en does not block the transfer.
REQ-025 A WRCR mode change takes effect on done in the cycle after the edge.

Reset
REQ-026 rst=1 clears, asynchronously: cr, wcr, ar, wc and ac to 0; dout to 0; dout_valid to 0.
REQ-027 After reset, done=1 (mode 00, wc=0) and addr=0.
REQ-028 Reset mid-transfer aborts without completing the step; operation resumes on the first edge after rst falls.

Structure
REQ-029 Package dma_pkg holds the opcode constants, the cr mode/direction constants and the default W.
REQ-030 One sub-module, dma_counter: W-bit register with load, up/down step and async reset; instantiated twice (ac, wc).
REQ-031 The opcode decode and the done compare stay in dma_addr_gen.

Verification
REQ-032 Reset, then idle -> addr=0, done=1, dout_valid=0, dout=0.
REQ-033 WRCR 0, WRAR 0x10, WRWC 3, then 3 cnt_en pulses -> addr steps 0x11, 0x12, 0x13; done rises after the 3rd pulse; a 4th pulse leaves addr=0x13.
REQ-034 WRCR 0b101 (decrement, mode 01), WRAR 0x00, WRWC 2 then LDWC 0, two transfers -> addr=0xFE (wrap); done=1 once wc=2; RDWC returns 0x02 with dout_valid for one cycle.
REQ-035 Mode 10, wcr=0x05, ar=0x02, cnt_en held high -> addr stops at 0x05 with done=1; REINIT -> addr=0x02, done=0.
REQ-036 cnt_en=1 coincident with LDAC 0x40 -> addr=0x40, no step; cnt_en coincident with RDAC -> dout=pre-step value and addr steps.
REQ-037 Assert rst mid-sequence, between edges -> all outputs clear immediately; done=1.
